solver_scheduler: RTL and testbench

Dispatches Mandelbrot pixel jobs across NUM_SOLVERS solver cores and collects their iteration counts.
- Accepts a limb-serial job stream (c real/imag limbs plus a tag).
- Round-robin picks a free core and loads c, num_limbs and iter_lim into it, then pulses start.
- Returns tagged results on a valid/ready port.
- Sits between the host/tile-walker and the array of solver instances.

---
 rtl/solver_pkg.sv | 22 ++
 rtl/rr_arbiter.sv | 31 +++
 rtl/solver_scheduler.sv | 234 +++++++++++++++++++++++
 tb/tb_solver_scheduler.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/solver_pkg.sv
// Shared encodings and constants for the Mandelbrot solver scheduler.
package solver_pkg;

  localparam int unsigned ITERATION_WIDTH    = 16;
  localparam int unsigned START_BLANK_CYCLES = 2;
  localparam int unsigned BLANK_CNT_BITS     = 2;

  typedef enum logic [1:0] {
    CoreFree,
    CoreLoading,
    CoreRunning,
    CoreDone
  } core_state_e;

  typedef enum logic [1:0] {
    LdIdle,
    LdLoad,
    LdCfg,
    LdStart
  } loader_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first requester at or after the pointer, wrapping.
module rr_arbiter #(
  parameter int unsigned NUM_REQ  = 4,
  parameter int unsigned SEL_BITS = 2
) (
  input  logic [NUM_REQ-1:0]  i_req,
  input  logic [SEL_BITS-1:0] i_ptr,
  output logic [NUM_REQ-1:0]  o_gnt,
  output logic [SEL_BITS-1:0] o_idx,
  output logic                o_any
);

  logic [SEL_BITS-1:0] w_cand;

  // NUM_REQ == 2**SEL_BITS, so the candidate index wraps for free.
  always_comb begin
    o_gnt  = '0;
    o_idx  = '0;
    o_any  = 1'b0;
    w_cand = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      w_cand = i_ptr + SEL_BITS'(i);
      if (!o_any && i_req[w_cand]) begin
        o_any         = 1'b1;
        o_idx         = w_cand;
        o_gnt[w_cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/solver_scheduler.sv
// Dispatches limb-serial Mandelbrot jobs to a pool of solver cores and returns tagged
// iteration counts through a valid/ready result port.
module solver_scheduler
  import solver_pkg::*;
#(
  parameter int unsigned NUM_SOLVERS     = 4,
  parameter int unsigned SOLVER_SEL_BITS = 2,
  parameter int unsigned LIMB_INDEX_BITS = 6,
  parameter int unsigned LIMB_SIZE_BITS  = 27,
  parameter int unsigned TAG_BITS        = 16,
  parameter int unsigned ITER_LIM_RESET  = 256
) (
  input  logic                                   clock,
  input  logic                                   reset,
  input  logic                                   cfg_iter_lim_en,
  input  logic [ITERATION_WIDTH-1:0]             cfg_iter_lim,
  input  logic                                   job_valid,
  output logic                                   job_ready,
  input  logic [LIMB_SIZE_BITS-1:0]              job_re,
  input  logic [LIMB_SIZE_BITS-1:0]              job_im,
  input  logic [TAG_BITS-1:0]                    job_tag,
  input  logic                                   job_last,
  output logic                                   res_valid,
  input  logic                                   res_ready,
  output logic [ITERATION_WIDTH-1:0]             res_iterations,
  output logic [TAG_BITS-1:0]                    res_tag,
  output logic [SOLVER_SEL_BITS-1:0]             res_solver,
  output logic                                   err_overflow,
  output logic                                   all_idle,
  output logic [NUM_SOLVERS-1:0]                 sol_wr_real_en,
  output logic [NUM_SOLVERS-1:0]                 sol_wr_imag_en,
  output logic [LIMB_INDEX_BITS-1:0]             sol_wr_index,
  output logic [LIMB_SIZE_BITS-1:0]              sol_real_data,
  output logic [LIMB_SIZE_BITS-1:0]              sol_imag_data,
  output logic [NUM_SOLVERS-1:0]                 sol_wr_num_limbs_en,
  output logic [LIMB_INDEX_BITS-1:0]             sol_num_limbs_data,
  output logic [NUM_SOLVERS-1:0]                 sol_wr_iter_lim_en,
  output logic [ITERATION_WIDTH-1:0]             sol_iter_lim_data,
  output logic [NUM_SOLVERS-1:0]                 sol_start,
  input  logic [NUM_SOLVERS-1:0]                 sol_out_ready,
  input  logic [ITERATION_WIDTH*NUM_SOLVERS-1:0] sol_iterations
);

  localparam logic [LIMB_INDEX_BITS-1:0] MAX_LIMBS = '1;

  loader_state_e                r_ld_state;
  logic [SOLVER_SEL_BITS-1:0]   r_ld_core;
  logic [SOLVER_SEL_BITS-1:0]   r_load_ptr;
  logic [LIMB_INDEX_BITS-1:0]   r_beat;
  logic                         r_err_overflow;
  logic [ITERATION_WIDTH-1:0]   r_iter_lim;
  logic                         r_all_idle;

  core_state_e                  r_core_state [NUM_SOLVERS];
  logic [BLANK_CNT_BITS-1:0]    r_blank      [NUM_SOLVERS];
  logic [ITERATION_WIDTH-1:0]   r_core_iter  [NUM_SOLVERS];
  logic [TAG_BITS-1:0]          r_core_tag   [NUM_SOLVERS];

  logic                         r_res_valid;
  logic [NUM_SOLVERS-1:0]       r_res_sel;
  logic [SOLVER_SEL_BITS-1:0]   r_res_solver;
  logic [SOLVER_SEL_BITS-1:0]   r_res_ptr;
  logic [ITERATION_WIDTH-1:0]   r_res_iterations;
  logic [TAG_BITS-1:0]          r_res_tag;

  logic [NUM_SOLVERS-1:0]       w_free_req, w_done_req, w_free_gnt, w_done_gnt, w_ld_sel;
  logic [SOLVER_SEL_BITS-1:0]   w_free_idx, w_done_idx;
  logic                         w_free_any, w_done_any;
  logic                         w_dispatch, w_beat_acc, w_beat_write, w_res_hs;

  always_comb begin
    w_free_req = '0;
    w_done_req = '0;
    w_ld_sel   = '0;
    for (int unsigned k = 0; k < NUM_SOLVERS; k++) begin
      w_free_req[k] = (r_core_state[k] == CoreFree);
      w_done_req[k] = (r_core_state[k] == CoreDone);
    end
    w_ld_sel[r_ld_core] = 1'b1;
  end

  assign w_dispatch   = (r_ld_state == LdIdle) && w_free_any;
  assign w_beat_acc   = (r_ld_state == LdLoad) && job_valid;
  assign w_beat_write = w_beat_acc && (r_beat != MAX_LIMBS);
  assign w_res_hs     = r_res_valid && res_ready;

  rr_arbiter #(
    .NUM_REQ  (NUM_SOLVERS),
    .SEL_BITS (SOLVER_SEL_BITS)
  ) u_free_arb (
    .i_req (w_free_req),
    .i_ptr (r_load_ptr),
    .o_gnt (w_free_gnt),
    .o_idx (w_free_idx),
    .o_any (w_free_any)
  );

  rr_arbiter #(
    .NUM_REQ  (NUM_SOLVERS),
    .SEL_BITS (SOLVER_SEL_BITS)
  ) u_done_arb (
    .i_req (w_done_req),
    .i_ptr (r_res_ptr),
    .o_gnt (w_done_gnt),
    .o_idx (w_done_idx),
    .o_any (w_done_any)
  );

  // Loader FSM; the beat counter saturates at MAX_LIMBS and doubles as num_limbs.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_ld_state     <= LdIdle;
      r_ld_core      <= '0;
      r_load_ptr     <= '0;
      r_beat         <= '0;
      r_err_overflow <= 1'b0;
    end else begin
      unique case (r_ld_state)
        LdIdle: begin
          if (w_free_any) begin
            r_ld_core  <= w_free_idx;
            r_beat     <= '0;
            r_ld_state <= LdLoad;
          end
        end
        LdLoad: begin
          if (job_valid) begin
            if (r_beat != MAX_LIMBS) r_beat <= r_beat + 1'b1;
            else                     r_err_overflow <= 1'b1;
            if (job_last) r_ld_state <= LdCfg;
          end
        end
        LdCfg: r_ld_state <= LdStart;
        LdStart: begin
          r_load_ptr <= r_ld_core + 1'b1;
          r_ld_state <= LdIdle;
        end
        default: r_ld_state <= LdIdle;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_iter_lim <= ITERATION_WIDTH'(ITER_LIM_RESET);
      r_all_idle <= 1'b0;
    end else begin
      if (cfg_iter_lim_en) r_iter_lim <= cfg_iter_lim;
      r_all_idle <= (r_ld_state == LdIdle) && (&w_free_req);
    end
  end

  // Per-core lifecycle; the blank counter masks a stale done flag right after start.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int unsigned k = 0; k < NUM_SOLVERS; k++) begin
        r_core_state[k] <= CoreFree;
        r_blank[k]      <= '0;
        r_core_iter[k]  <= '0;
        r_core_tag[k]   <= '0;
      end
    end else begin
      for (int unsigned k = 0; k < NUM_SOLVERS; k++) begin
        unique case (r_core_state[k])
          CoreFree: begin
            if (w_dispatch && w_free_gnt[k]) r_core_state[k] <= CoreLoading;
          end
          CoreLoading: begin
            if (w_beat_acc && (r_beat == '0) && w_ld_sel[k]) r_core_tag[k] <= job_tag;
            if ((r_ld_state == LdStart) && w_ld_sel[k]) begin
              r_core_state[k] <= CoreRunning;
              r_blank[k]      <= BLANK_CNT_BITS'(START_BLANK_CYCLES);
            end
          end
          CoreRunning: begin
            if (r_blank[k] != '0) begin
              r_blank[k] <= r_blank[k] - 1'b1;
            end else if (sol_out_ready[k]) begin
              r_core_state[k] <= CoreDone;
              r_core_iter[k]  <= sol_iterations[k*ITERATION_WIDTH +: ITERATION_WIDTH];
            end
          end
          CoreDone: begin
            if (w_res_hs && r_res_sel[k]) r_core_state[k] <= CoreFree;
          end
          default: r_core_state[k] <= CoreFree;
        endcase
      end
    end
  end

  // Result register only reloads while empty, giving a bubble after every handshake.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_res_valid      <= 1'b0;
      r_res_sel        <= '0;
      r_res_solver     <= '0;
      r_res_ptr        <= '0;
      r_res_iterations <= '0;
      r_res_tag        <= '0;
    end else if (r_res_valid) begin
      if (res_ready) begin
        r_res_valid <= 1'b0;
        r_res_ptr   <= r_res_solver + 1'b1;
      end
    end else if (w_done_any) begin
      r_res_valid      <= 1'b1;
      r_res_sel        <= w_done_gnt;
      r_res_solver     <= w_done_idx;
      r_res_iterations <= r_core_iter[w_done_idx];
      r_res_tag        <= r_core_tag[w_done_idx];
    end
  end

  assign job_ready           = (r_ld_state == LdLoad);
  assign sol_wr_real_en      = w_beat_write ? w_ld_sel : '0;
  assign sol_wr_imag_en      = w_beat_write ? w_ld_sel : '0;
  assign sol_wr_index        = job_ready ? r_beat : '0;
  assign sol_real_data       = job_ready ? job_re : '0;
  assign sol_imag_data       = job_ready ? job_im : '0;
  assign sol_wr_num_limbs_en = (r_ld_state == LdCfg) ? w_ld_sel : '0;
  assign sol_num_limbs_data  = (r_ld_state == LdCfg) ? r_beat : '0;
  assign sol_wr_iter_lim_en  = (r_ld_state == LdCfg) ? w_ld_sel : '0;
  assign sol_iter_lim_data   = (r_ld_state == LdCfg) ? r_iter_lim : '0;
  assign sol_start           = (r_ld_state == LdStart) ? w_ld_sel : '0;

  assign res_valid      = r_res_valid;
  assign res_iterations = r_res_iterations;
  assign res_tag        = r_res_tag;
  assign res_solver     = r_res_solver;
  assign err_overflow   = r_err_overflow;
  assign all_idle       = r_all_idle;

endmodule

// File: tb/tb_solver_scheduler.sv
// Directed self-checking bench for solver_scheduler; the bench plays the solver cores.
module tb_solver_scheduler;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        cfg_iter_lim_en = 1'b0;
  logic [15:0] cfg_iter_lim = '0;
  logic        job_valid = 1'b0;
  logic        job_ready;
  logic [26:0] job_re = '0;
  logic [26:0] job_im = '0;
  logic [15:0] job_tag = '0;
  logic        job_last = 1'b0;
  logic        res_valid;
  logic        res_ready = 1'b0;
  logic [15:0] res_iterations;
  logic [15:0] res_tag;
  logic [1:0]  res_solver;
  logic        err_overflow;
  logic        all_idle;
  logic [3:0]  sol_wr_real_en, sol_wr_imag_en;
  logic [5:0]  sol_wr_index;
  logic [26:0] sol_real_data, sol_imag_data;
  logic [3:0]  sol_wr_num_limbs_en;
  logic [5:0]  sol_num_limbs_data;
  logic [3:0]  sol_wr_iter_lim_en;
  logic [15:0] sol_iter_lim_data;
  logic [3:0]  sol_start;
  logic [3:0]  sol_out_ready = '0;
  logic [63:0] sol_iterations = '0;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clock = ~clock;

  solver_scheduler dut (
    .clock               (clock),
    .reset               (reset),
    .cfg_iter_lim_en     (cfg_iter_lim_en),
    .cfg_iter_lim        (cfg_iter_lim),
    .job_valid           (job_valid),
    .job_ready           (job_ready),
    .job_re              (job_re),
    .job_im              (job_im),
    .job_tag             (job_tag),
    .job_last            (job_last),
    .res_valid           (res_valid),
    .res_ready           (res_ready),
    .res_iterations      (res_iterations),
    .res_tag             (res_tag),
    .res_solver          (res_solver),
    .err_overflow        (err_overflow),
    .all_idle            (all_idle),
    .sol_wr_real_en      (sol_wr_real_en),
    .sol_wr_imag_en      (sol_wr_imag_en),
    .sol_wr_index        (sol_wr_index),
    .sol_real_data       (sol_real_data),
    .sol_imag_data       (sol_imag_data),
    .sol_wr_num_limbs_en (sol_wr_num_limbs_en),
    .sol_num_limbs_data  (sol_num_limbs_data),
    .sol_wr_iter_lim_en  (sol_wr_iter_lim_en),
    .sol_iter_lim_data   (sol_iter_lim_data),
    .sol_start           (sol_start),
    .sol_out_ready       (sol_out_ready),
    .sol_iterations      (sol_iterations)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic apply_reset();
    job_valid       = 1'b0;
    job_last        = 1'b0;
    res_ready       = 1'b0;
    cfg_iter_lim_en = 1'b0;
    sol_out_ready   = '0;
    reset           = 1'b0;
    step();
    step();
    @(negedge clock);
    reset = 1'b1;
    step();
  endtask

  task automatic wait_ready(input string tag);
    int n = 0;
    while (!job_ready && n < 50) begin
      step();
      n++;
    end
    check_eq(tag, job_ready, 1);
  endtask

  task automatic wait_res(input string tag);
    int n = 0;
    while (!res_valid && n < 50) begin
      step();
      n++;
    end
    check_eq(tag, res_valid, 1);
  endtask

  task automatic handshake();
    res_ready = 1'b1;
    step();
    res_ready = 1'b0;
  endtask

  // Drives one job and checks every write strobe, the CFG cycle and the start pulse.
  task automatic send_job(input int core, input logic [15:0] tag, input int nbeats,
                          input logic [15:0] lim);
    logic [3:0] sel;
    sel = 4'(1 << core);
    wait_ready("job_ready_wait");
    for (int b = 0; b < nbeats; b++) begin
      job_valid = 1'b1;
      job_last  = (b == nbeats - 1);
      job_tag   = (b == 0) ? tag : ~tag;
      job_re    = 27'(b * 7 + 3);
      job_im    = 27'(b * 11 + 5);
      #1;
      check_eq("ready_beat", job_ready, 1);
      if (b < 63) begin
        check_eq("wr_real_en", sol_wr_real_en, sel);
        check_eq("wr_imag_en", sol_wr_imag_en, sel);
        check_eq("wr_index", sol_wr_index, b);
      end else begin
        check_eq("wr_en_ovf", {sol_wr_real_en, sol_wr_imag_en}, 0);
      end
      check_eq("real_data", sol_real_data, 27'(b * 7 + 3));
      check_eq("imag_data", sol_imag_data, 27'(b * 11 + 5));
      step();
    end
    job_valid = 1'b0;
    job_last  = 1'b0;
    #1;
    check_eq("num_limbs_en", sol_wr_num_limbs_en, sel);
    check_eq("num_limbs", sol_num_limbs_data, (nbeats > 63) ? 63 : nbeats);
    check_eq("iter_lim_en", sol_wr_iter_lim_en, sel);
    check_eq("iter_lim", sol_iter_lim_data, lim);
    check_eq("start_early", sol_start, 0);
    step();
    check_eq("start", sol_start, sel);
    step();
    check_eq("start_once", sol_start, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    #1;
    check_eq("rst_job_ready", job_ready, 0);
    check_eq("rst_res_valid", res_valid, 0);
    check_eq("rst_all_idle", all_idle, 0);
    check_eq("rst_err", err_overflow, 0);
    check_eq("rst_start", sol_start, 0);

    apply_reset();
    check_eq("all_idle_first", all_idle, 1);
    step();
    check_eq("all_idle_loading", all_idle, 0);

    // Single 3-beat job with a reprogrammed limit.
    cfg_iter_lim_en = 1'b1;
    cfg_iter_lim    = 16'd100;
    step();
    cfg_iter_lim_en = 1'b0;
    send_job(0, 16'h00A5, 3, 16'd100);
    sol_iterations[15:0] = 16'd42;
    sol_out_ready[0]     = 1'b1;
    wait_res("t1_res_wait");
    check_eq("t1_iter", res_iterations, 42);
    check_eq("t1_tag", res_tag, 16'h00A5);
    check_eq("t1_solver", res_solver, 0);
    handshake();
    sol_out_ready[0] = 1'b0;
    check_eq("t1_res_cleared", res_valid, 0);

    // Round-robin dispatch and stall with every core busy.
    apply_reset();
    for (int c = 0; c < 4; c++) send_job(c, 16'(c + 1), 1, 16'd256);
    repeat (5) step();
    check_eq("t2_stall", job_ready, 0);
    sol_iterations[47:32] = 16'd7;
    sol_out_ready[2]      = 1'b1;
    wait_res("t2_res_wait");
    check_eq("t2_solver", res_solver, 2);
    check_eq("t2_iter", res_iterations, 7);
    check_eq("t2_tag", res_tag, 3);
    check_eq("t2_still_stalled", job_ready, 0);
    handshake();
    sol_out_ready[2] = 1'b0;
    send_job(2, 16'h0055, 1, 16'd256);

    // Two simultaneous finishers under back-pressure.
    apply_reset();
    for (int c = 0; c < 4; c++) send_job(c, 16'(c + 16), 1, 16'd256);
    sol_iterations[31:16] = 16'd11;
    sol_iterations[63:48] = 16'd33;
    sol_out_ready         = 4'b1010;
    wait_res("t3_res_wait");
    check_eq("t3_first_solver", res_solver, 1);
    for (int i = 0; i < 5; i++) begin
      step();
      check_eq("t3_hold_valid", res_valid, 1);
      check_eq("t3_hold_solver", res_solver, 1);
      check_eq("t3_hold_iter", res_iterations, 11);
      check_eq("t3_hold_tag", res_tag, 16'h0011);
    end
    handshake();
    sol_out_ready[1] = 1'b0;
    check_eq("t3_bubble", res_valid, 0);
    step();
    check_eq("t3_second_valid", res_valid, 1);
    check_eq("t3_second_solver", res_solver, 3);
    check_eq("t3_second_iter", res_iterations, 33);
    check_eq("t3_second_tag", res_tag, 16'h0013);
    handshake();
    sol_out_ready[3] = 1'b0;
    send_job(1, 16'h0101, 1, 16'd256);
    send_job(3, 16'h0303, 1, 16'd256);

    // Overlong job saturates num_limbs and flags overflow.
    apply_reset();
    check_eq("t4_err_clear", err_overflow, 0);
    send_job(0, 16'hBEEF, 70, 16'd256);
    check_eq("t4_err_set", err_overflow, 1);

    // Stale done flag is blanked for two cycles after start.
    apply_reset();
    sol_iterations[15:0] = 16'd5;
    sol_out_ready[0]     = 1'b1;
    send_job(0, 16'h0077, 1, 16'd256);
    for (int i = 0; i < 4; i++) begin
      check_eq("t5_blank", res_valid, 0);
      step();
    end
    check_eq("t5_done", res_valid, 1);
    check_eq("t5_iter", res_iterations, 5);
    handshake();
    sol_out_ready[0] = 1'b0;

    // Reset in the middle of a load.
    apply_reset();
    cfg_iter_lim_en = 1'b1;
    cfg_iter_lim    = 16'd100;
    step();
    cfg_iter_lim_en = 1'b0;
    wait_ready("t6_ready_wait");
    for (int b = 0; b < 2; b++) begin
      job_valid = 1'b1;
      job_last  = 1'b0;
      job_tag   = 16'h1234;
      job_re    = 27'(b + 100);
      job_im    = 27'(b + 200);
      step();
    end
    job_valid = 1'b0;
    #2;
    reset = 1'b0;
    #1;
    check_eq("t6_ready", job_ready, 0);
    check_eq("t6_wr_en", sol_wr_real_en, 0);
    check_eq("t6_index", sol_wr_index, 0);
    check_eq("t6_data", sol_real_data, 0);
    check_eq("t6_all_idle", all_idle, 0);
    @(negedge clock);
    reset = 1'b1;
    step();
    send_job(0, 16'h0099, 2, 16'd256);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
